// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the front-end pipeline blocks.
//   XLEN       : width of pc and instruction words
//   NOP_INSTR  : instruction presented to decode when no real entry is available
//                (addi x0, x0, 0)
//   IFQ_DEPTH  : default depth of the fetch/decode instruction queue
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned IFQ_DEPTH = 4;

endpackage : cpu_pkg

// File: rtl/ptr_counter.sv
// Wrapping pointer for a power-of-two ring buffer.
// Ports:
//   clk_i   : clock, all updates on posedge
//   clr_i   : synchronous active-high reset, pointer -> 0
//   clear_i : synchronous pointer clear (e.g. pipeline flush), pointer -> 0
//   inc_i   : advance pointer by one, wrapping modulo 2**W
//   ptr_o   : current pointer value
module ptr_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: clear wins over increment; natural overflow gives the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = {W{1'b0}};
    end else if (inc_i) begin
      ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      ptr_q <= {W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : ptr_counter

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch (writer) and decode (reader).
// Fetch pushes {pc, instr} pairs; decode consumes the head unless stalled.
// A taken-branch flush or clr empties the queue.
// Ports:
//   clk        : clock
//   clr        : synchronous active-high reset
//   push_valid : fetch offers {push_pc, push_instr} this cycle
//   push_ready : queue can accept (not full); depends on registered count only
//   push_pc    : pc of the offered instruction
//   push_instr : offered instruction word
//   stall      : load-use stall, holds the head entry
//   flush      : branch taken, discard all entries (a same-cycle push is dropped)
//   id_valid   : head entry valid
//   id_pc      : head pc, 0 when empty
//   id_instr   : head instruction, NOP_INSTR when empty
//   count      : occupancy 0..DEPTH
module fetch_decode_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH     = cpu_pkg::IFQ_DEPTH,
  parameter int unsigned XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR[XLEN-1:0]
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [XLEN-1:0]          push_instr,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned W_PTR = $clog2(DEPTH);
  localparam int unsigned W_CNT = W_PTR + 1;
  localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(DEPTH);
  localparam logic [W_CNT-1:0] ONE_CNT  = {{(W_CNT-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [W_CNT-1:0]  count_q;
  logic [W_CNT-1:0]  count_d;
  logic [W_PTR-1:0]  rd_ptr_s;
  logic [W_PTR-1:0]  wr_ptr_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_en_s;
  entry_t            head_s;

  // Handshake terms come from registered count only, so push_ready has no
  // path from stall and an empty queue ignores stall automatically.
  assign push_ready = (count_q != FULL_CNT);
  assign id_valid   = (count_q != {W_CNT{1'b0}});
  assign push_s     = push_valid & push_ready;
  assign pop_s      = id_valid & ~stall;
  // A flush drops any push offered in the same cycle.
  assign wr_en_s    = push_s & ~flush;

  ptr_counter #(.W(W_PTR)) u_rd_ptr (
    .clk_i   (clk),
    .clr_i   (clr),
    .clear_i (flush),
    .inc_i   (pop_s),
    .ptr_o   (rd_ptr_s)
  );

  ptr_counter #(.W(W_PTR)) u_wr_ptr (
    .clk_i   (clk),
    .clr_i   (clr),
    .clear_i (flush),
    .inc_i   (wr_en_s),
    .ptr_o   (wr_ptr_s)
  );

  // Occupancy next-state: flush empties; otherwise +1/-1/hold by push/pop.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {W_CNT{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        2'b11:   count_d = count_q;
        2'b00:   count_d = count_q;
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= {W_CNT{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage; contents are irrelevant while count says they are empty,
  // so no reset is applied here.
  always_ff @(posedge clk) begin
    if (wr_en_s && !clr) begin
      mem_q[wr_ptr_s] <= '{pc: push_pc, instr: push_instr};
    end
  end

  // Head presentation: empty queue shows pc 0 and a NOP to decode.
  always_comb begin
    head_s = mem_q[rd_ptr_s];
    if (id_valid) begin
      id_pc    = head_s.pc;
      id_instr = head_s.instr;
    end else begin
      id_pc    = {XLEN{1'b0}};
      id_instr = NOP_INSTR;
    end
  end

  assign count = count_q;

endmodule : fetch_decode_queue
